aes_mm2s_cntrl_tx: RTL

//  Transmit end of the MM2S control stream that mm2s_cntrl receives: emits one 6-beat
//  AXI4-Stream control packet (flag word + APP0..APP4) per accepted AES command.

---
 rtl/aes_mm2s_cntrl_tx_pkg.sv | 28 ++
 rtl/aes_credit_cnt.sv | 49 ++++
 rtl/aes_mm2s_cntrl_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/aes_mm2s_cntrl_tx_pkg.sv
// Shared definitions for the MM2S control-stream transmitter: flag word, APP word
// count, FSM states and the APP word selector used by the beat mux.
package aes_mm2s_cntrl_tx_pkg;

   localparam logic [31:0] CNTRL_FLAG      = 32'hA000_0000;
   localparam int          CNTRL_APP_WORDS = 5;
   localparam logic [2:0]  LAST_APP_IDX    = 3'(CNTRL_APP_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FLAG = 2'd1,
      ST_APP  = 2'd2
   } cntrl_state_t;

   function automatic logic [31:0] app_word(input logic [159:0] hold, input logic [2:0] idx);
      logic [31:0] w;
      case (idx)
         3'd0:    w = hold[31:0];
         3'd1:    w = hold[63:32];
         3'd2:    w = hold[95:64];
         3'd3:    w = hold[127:96];
         3'd4:    w = hold[159:128];
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/aes_credit_cnt.sv
// Outstanding-packet counter: up on command accept, down on data-frame end,
// with a look-ahead "below max" compare and a sticky underflow flag.
module aes_credit_cnt #(
   parameter int C_MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] cnt,
   output logic       below_max_next,
   output logic       underflow
);

   localparam logic [3:0] MAX_CNT = 4'(C_MAX);

   logic [3:0] cnt_nxt;
   logic       underflow_nxt;

   // A simultaneous inc and dec cancel, even at zero, so no underflow is flagged then.
   always_comb begin
      cnt_nxt       = cnt;
      underflow_nxt = underflow;
      if (inc && !dec) begin
         cnt_nxt = cnt + 4'd1;
      end else if (dec && !inc) begin
         if (cnt == 4'd0) begin
            underflow_nxt = 1'b1;
         end else begin
            cnt_nxt = cnt - 4'd1;
         end
      end else begin
         cnt_nxt = cnt;
      end
   end

   assign below_max_next = (cnt_nxt < MAX_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= 4'd0;
         underflow <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         underflow <= underflow_nxt;
      end
   end

endmodule

// File: rtl/aes_mm2s_cntrl_tx.sv
// MM2S control-stream transmitter: one 6-beat packet (flag + APP0..APP4) per accepted
// command, throttled by the number of packets still waiting for their data frame.
module aes_mm2s_cntrl_tx
   import aes_mm2s_cntrl_tx_pkg::*;
#(
   parameter int C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH = 32,
   parameter int C_MAX_OUTSTANDING               = 4
) (
   input  logic                                         m_axi_mm2s_aclk,
   input  logic                                         mm2s_cntrl_reset,
   input  logic                                         cmd_valid,
   output logic                                         cmd_ready,
   input  logic [159:0]                                 cmd_app,
   output logic [C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH-1:0]   m_axis_mm2s_cntrl_tdata,
   output logic [C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH/8-1:0] m_axis_mm2s_cntrl_tkeep,
   output logic                                         m_axis_mm2s_cntrl_tvalid,
   output logic                                         m_axis_mm2s_cntrl_tlast,
   input  logic                                         m_axis_mm2s_cntrl_tready,
   input  logic                                         m_axis_mm2s_tvalid,
   input  logic                                         m_axis_mm2s_tready,
   input  logic                                         m_axis_mm2s_tlast,
   output logic [3:0]                                   outstanding,
   output logic                                         busy,
   output logic                                         err_underflow
);

   localparam int W = C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH;

   cntrl_state_t state_r, state_nxt;
   logic [2:0]   idx_r, idx_nxt;
   logic [159:0] hold_r, hold_nxt;
   logic [W-1:0] tdata_r, tdata_nxt;
   logic         tvalid_r, tvalid_nxt;
   logic         tlast_r, tlast_nxt;
   logic         cmd_ready_r, cmd_ready_nxt;
   logic         busy_r, busy_nxt;
   logic         accept_s, frame_end_s, below_max_next_s;

   // cmd_ready_r is only ever high in IDLE, so it alone qualifies an accept.
   assign accept_s    = cmd_valid && cmd_ready_r;
   assign frame_end_s = m_axis_mm2s_tvalid && m_axis_mm2s_tready && m_axis_mm2s_tlast;

   aes_credit_cnt #(.C_MAX(C_MAX_OUTSTANDING)) u_credit (
      .clk            (m_axi_mm2s_aclk),
      .rst            (mm2s_cntrl_reset),
      .inc            (accept_s),
      .dec            (frame_end_s),
      .cnt            (outstanding),
      .below_max_next (below_max_next_s),
      .underflow      (err_underflow)
   );

   always_comb begin
      state_nxt  = state_r;
      idx_nxt    = idx_r;
      hold_nxt   = hold_r;
      tdata_nxt  = tdata_r;
      tvalid_nxt = tvalid_r;
      tlast_nxt  = tlast_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               hold_nxt   = cmd_app;
               state_nxt  = ST_FLAG;
               tvalid_nxt = 1'b1;
               tdata_nxt  = CNTRL_FLAG;
               tlast_nxt  = 1'b0;
            end else begin
               tvalid_nxt = 1'b0;
            end
         end
         ST_FLAG: begin
            if (m_axis_mm2s_cntrl_tready) begin
               state_nxt = ST_APP;
               idx_nxt   = 3'd0;
               tdata_nxt = app_word(hold_r, 3'd0);
               tlast_nxt = (LAST_APP_IDX == 3'd0);
            end else begin
               state_nxt = ST_FLAG;
            end
         end
         ST_APP: begin
            if (m_axis_mm2s_cntrl_tready) begin
               if (idx_r == LAST_APP_IDX) begin
                  state_nxt  = ST_IDLE;
                  idx_nxt    = 3'd0;
                  tvalid_nxt = 1'b0;
                  tlast_nxt  = 1'b0;
                  tdata_nxt  = {W{1'b0}};
               end else begin
                  idx_nxt   = idx_r + 3'd1;
                  tdata_nxt = app_word(hold_r, idx_r + 3'd1);
                  tlast_nxt = ((idx_r + 3'd1) == LAST_APP_IDX);
               end
            end else begin
               state_nxt = ST_APP;
            end
         end
         default: begin
            state_nxt  = ST_IDLE;
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
         end
      endcase
      cmd_ready_nxt = (state_nxt == ST_IDLE) && below_max_next_s;
      busy_nxt      = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge m_axi_mm2s_aclk or posedge mm2s_cntrl_reset) begin
      if (mm2s_cntrl_reset) begin
         state_r     <= ST_IDLE;
         idx_r       <= 3'd0;
         hold_r      <= 160'h0;
         tdata_r     <= {W{1'b0}};
         tvalid_r    <= 1'b0;
         tlast_r     <= 1'b0;
         cmd_ready_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt;
         idx_r       <= idx_nxt;
         hold_r      <= hold_nxt;
         tdata_r     <= tdata_nxt;
         tvalid_r    <= tvalid_nxt;
         tlast_r     <= tlast_nxt;
         cmd_ready_r <= cmd_ready_nxt;
         busy_r      <= busy_nxt;
      end
   end

   assign m_axis_mm2s_cntrl_tdata  = tdata_r;
   assign m_axis_mm2s_cntrl_tkeep  = {(W/8){1'b1}};
   assign m_axis_mm2s_cntrl_tvalid = tvalid_r;
   assign m_axis_mm2s_cntrl_tlast  = tlast_r;
   assign cmd_ready                = cmd_ready_r;
   assign busy                     = busy_r;

endmodule
